// File: rtl/mcu_seq_pkg.sv
// mcu_seq_pkg: shared state type and constants for the 8051 multiplier sequencer.
package mcu_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, LOAD_END, SETTLE, READ, DONE} state_e;
  localparam logic [1:0] BYTE_MSB = 2'd0;
  localparam logic [1:0] BYTE_LSB = 2'd3;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: synchronizes an asynchronous strobe and flags its rising edge for one clock.
module sync_edge import mcu_seq_pkg::*; #(
  parameter int DEPTH = SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic ev_o
);
  logic [DEPTH-1:0] s_q;
  logic prev_q, vld_q, arm_q;
  // arm_q requires a genuinely sampled low first, so a strobe held across reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      prev_q <= 1'b0;
      vld_q  <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      s_q    <= {s_q[DEPTH-2:0], d_i};
      prev_q <= s_q[DEPTH-1];
      vld_q  <= 1'b1;
      arm_q  <= arm_q | (vld_q & ~s_q[0]);
    end
  end
  assign ev_o = s_q[DEPTH-1] & ~prev_q & arm_q;
endmodule

// File: rtl/mcu_mul_sequencer.sv
// mcu_mul_sequencer: turns 8051 port strobes into a 16x16 multiplier load, settle and readout.
// Define MCU_SEQ_TIMEOUT_EN to build the load-phase watchdog.
module mcu_mul_sequencer import mcu_seq_pkg::*; #(
  parameter int SETTLE_CYCLES  = 100,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mcu_data_in,
  input  logic       mcu_wr,
  input  logic       mcu_rd,
  output logic [7:0] mcu_data_out,
  output logic       mcu_ack,
  output logic       mcu_busy,
  output logic       mcu_err,
  output logic [7:0] mul_bus,
  output logic [1:0] mul_in_sel,
  output logic       mul_in_en,
  output logic [1:0] mul_out_sel,
  output logic       mul_out_en,
  input  logic [7:0] mul_bus_rd
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d, widx, in_sel_q, in_sel_d, out_sel_q, out_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0][7:0] res_q, res_d;
  logic [7:0] dout_q, dout_d, bus_q, bus_d;
  logic ack_q, ack_d, err_q, err_d, in_en_q, in_en_d, out_en_q, out_en_d;
  logic wr_ev, rd_ev, wr_ok;
`ifdef MCU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else tcnt_q <= tcnt_d;
  end
`endif
  sync_edge u_wr_sync (.clk(clk), .rst_n(rst_n), .d_i(mcu_wr), .ev_o(wr_ev));
  sync_edge u_rd_sync (.clk(clk), .rst_n(rst_n), .d_i(mcu_rd), .ev_o(rd_ev));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      dout_q    <= '0;
      bus_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      in_sel_q  <= '0;
      in_en_q   <= 1'b0;
      out_sel_q <= '0;
      out_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      dout_q    <= dout_d;
      bus_q     <= bus_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      in_sel_q  <= in_sel_d;
      in_en_q   <= in_en_d;
      out_sel_q <= out_sel_d;
      out_en_q  <= out_en_d;
    end
  end
  // a write in DONE abandons the result and restarts the operand load at the MSB
  assign wr_ok = wr_ev && (state_q == IDLE || state_q == LOAD || state_q == DONE);
  assign widx  = (state_q == DONE) ? BYTE_MSB : idx_q;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    dout_d    = dout_q;
    bus_d     = bus_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    in_sel_d  = in_sel_q;
    in_en_d   = in_en_q;
    out_sel_d = out_sel_q;
    out_en_d  = out_en_q;
`ifdef MCU_SEQ_TIMEOUT_EN
    tcnt_d    = '0;
`endif
    if (wr_ok) begin
      bus_d    = mcu_data_in;
      in_sel_d = widx;
      in_en_d  = 1'b1;
      ack_d    = 1'b1;
      idx_d    = widx + 2'd1;
      cnt_d    = '0;
      state_d  = (widx == BYTE_LSB) ? LOAD_END : LOAD;
      err_d    = (state_q == IDLE) ? 1'b0 : err_q;
    end else begin
      if (wr_ev || (rd_ev && state_q != DONE)) err_d = 1'b1;
      case (state_q)
`ifdef MCU_SEQ_TIMEOUT_EN
        LOAD: begin
          if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            in_en_d = 1'b0;
            err_d   = 1'b1;
            idx_d   = BYTE_MSB;
            state_d = IDLE;
          end else tcnt_d = tcnt_q + TW'(1);
        end
`endif
        LOAD_END: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(1)) begin
            in_en_d = 1'b0;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
            cnt_d     = '0;
            out_en_d  = 1'b1;
            out_sel_d = BYTE_MSB;
            idx_d     = BYTE_MSB;
            state_d   = READ;
          end
        end
        READ: begin
          cnt_d = CW'(1);
          if (cnt_q == CW'(1)) begin
            res_d[idx_q] = mul_bus_rd;
            cnt_d        = '0;
            idx_d        = idx_q + 2'd1;
            out_sel_d    = (idx_q == BYTE_LSB) ? idx_q : idx_q + 2'd1;
            out_en_d     = idx_q != BYTE_LSB;
            state_d      = (idx_q == BYTE_LSB) ? DONE : READ;
          end
        end
        DONE: begin
          if (rd_ev) begin
            dout_d  = res_q[idx_q];
            ack_d   = 1'b1;
            idx_d   = idx_q + 2'd1;
            state_d = (idx_q == BYTE_LSB) ? IDLE : DONE;
          end
        end
        default: ;
      endcase
    end
  end
  assign mcu_data_out = dout_q;
  assign mcu_ack      = ack_q;
  assign mcu_busy     = state_q inside {LOAD_END, SETTLE, READ};
  assign mcu_err      = err_q;
  assign mul_bus      = bus_q;
  assign mul_in_sel   = in_sel_q;
  assign mul_in_en    = in_en_q;
  assign mul_out_sel  = out_sel_q;
  assign mul_out_en   = out_en_q;
endmodule

// File: tb/tb_mcu_mul_sequencer.sv
// tb_mcu_mul_sequencer: directed strobe sequences against a 16x16 multiplier model, ack scoreboard.
module tb_mcu_mul_sequencer;
  localparam int SETTLE = 20;
  typedef struct {
    logic       rd;
    logic [7:0] d;
    logic [1:0] sel;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, mcu_wr = 1'b0, mcu_rd = 1'b0;
  logic [7:0] mcu_data_in = 8'h00;
  logic [7:0] mcu_data_out, mul_bus, mul_bus_rd;
  logic [1:0] mul_in_sel, mul_out_sel;
  logic mcu_ack, mcu_busy, mcu_err, mul_in_en, mul_out_en;
  logic [7:0] opb [4] = '{default: 8'h00};
  logic [31:0] prod;
  logic [24:0] outs;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, ack_cnt = 0, busy_cnt = 0;

  always #5 clk = ~clk;

  mcu_mul_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .mcu_data_in(mcu_data_in), .mcu_wr(mcu_wr), .mcu_rd(mcu_rd),
    .mcu_data_out(mcu_data_out), .mcu_ack(mcu_ack), .mcu_busy(mcu_busy), .mcu_err(mcu_err),
    .mul_bus(mul_bus), .mul_in_sel(mul_in_sel), .mul_in_en(mul_in_en),
    .mul_out_sel(mul_out_sel), .mul_out_en(mul_out_en), .mul_bus_rd(mul_bus_rd)
  );

  // multiplier model: latches operand bytes while enabled, presents product bytes MSB first
  always @(posedge clk) if (mul_in_en) opb[mul_in_sel] <= mul_bus;
  assign prod = {opb[0], opb[1]} * {opb[2], opb[3]};
  assign mul_bus_rd = mul_out_en ? prod[31 - 8 * mul_out_sel -: 8] : 8'h00;
  assign outs = {mcu_data_out, mcu_ack, mcu_busy, mcu_err, mul_bus, mul_in_sel, mul_in_en, mul_out_sel, mul_out_en};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mcu_busy) busy_cnt++;
    if (rst_n && mcu_ack) begin
      ack_cnt++;
      chk("ack_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.rd) chk("rd_data", {24'h0, mcu_data_out}, {24'h0, e.d});
        else chk("wr_bus", {21'h0, mul_in_en, mul_in_sel, mul_bus}, {21'h0, 1'b1, e.sel, e.d});
      end
    end
  end

  task automatic strobe(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    if (w) mcu_data_in = d;
    mcu_wr = w;
    mcu_rd = r;
    repeat (2) @(negedge clk);
    mcu_wr = 1'b0;
    mcu_rd = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d, input logic [1:0] sel);
    sb.push_back('{1'b0, d, sel});
    strobe(1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [7:0] d);
    sb.push_back('{1'b1, d, 2'd0});
    strobe(1'b0, 1'b1, 8'h00);
  endtask

  task automatic load4(input logic [31:0] v);
    for (int i = 0; i < 4; i++) wr(v[31 - 8 * i -: 8], 2'(i));
  endtask

  task automatic read4(input logic [31:0] p);
    for (int i = 0; i < 4; i++) rd(p[31 - 8 * i -: 8]);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && mcu_busy; i++) @(negedge clk);
    chk("busy_drop", {31'h0, mcu_busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_outputs", {7'h0, outs}, 0);
    ack_cnt = 0;
    load4(32'h000C_0018);
    wait_idle();
    read4(32'h0000_0120);
    chk("ack_total", ack_cnt, 8);
    chk("err_clean", {31'h0, mcu_err}, 0);
    busy_cnt = 0;
    load4(32'hFFFF_FFFF);
    wait_idle();
    chk("busy_len", busy_cnt, 2 + SETTLE + 8);
    read4(32'hFFFE_0001);
    strobe(1'b0, 1'b1, 8'h00);
    chk("rd_idle_err", {31'h0, mcu_err}, 1);
    chk("rd_idle_dout", {24'h0, mcu_data_out}, 32'h01);
    wr(8'h00, 2'd0);
    chk("idle_wr_clears_err", {31'h0, mcu_err}, 0);
    wr(8'h02, 2'd1);
    wr(8'h00, 2'd2);
    wr(8'h03, 2'd3);
    chk("busy_after_load", {31'h0, mcu_busy}, 1);
    strobe(1'b1, 1'b0, 8'h55);
    chk("settle_wr_err", {31'h0, mcu_err}, 1);
    wait_idle();
    read4(32'h0000_0006);
    chk("err_sticky", {31'h0, mcu_err}, 1);
    wr(8'h00, 2'd0);
    chk("err_cleared", {31'h0, mcu_err}, 0);
    wr(8'h07, 2'd1);
    wr(8'h00, 2'd2);
    wr(8'h02, 2'd3);
    wait_idle();
    read4(32'h0000_000E);
    load4(32'h1234_5678);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {7'h0, outs}, 0);
    mcu_rd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    mcu_rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_rd_no_event", {31'h0, mcu_err}, 0);
    load4(32'h0003_0005);
    wait_idle();
    read4(32'h0000_000F);
    load4(32'h0004_0004);
    wait_idle();
    rd(8'h00);
    rd(8'h00);
    sb.push_back('{1'b0, 8'h00, 2'd0});
    strobe(1'b1, 1'b1, 8'h00);
    chk("simul_no_err", {31'h0, mcu_err}, 0);
    wr(8'h0A, 2'd1);
    wr(8'h00, 2'd2);
    wr(8'h09, 2'd3);
    wait_idle();
    read4(32'h0000_005A);
`ifdef MCU_SEQ_TIMEOUT_EN
    wr(8'h11, 2'd0);
    wr(8'h22, 2'd1);
    repeat (20) @(negedge clk);
    chk("timeout_state", {29'h0, mcu_busy, mcu_err, mul_in_en}, 32'b010);
    load4(32'h0002_0008);
    wait_idle();
    read4(32'h0000_0010);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mcu_mul_sequencer.md
MCU_MUL_SEQUENCER -- requirements
Module: mcu_mul_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 100: idle clocks between the last operand load and the first result read.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: load-phase watchdog limit, used only with MCU_SEQ_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 mcu_data_in  in  8  operand byte from the 8051 port.
REQ-006 mcu_wr  in  1  asynchronous write strobe; active on its rising edge.
REQ-007 mcu_rd  in  1  asynchronous read strobe; active on its rising edge.
REQ-008 mcu_data_out  out  8  result byte to the 8051.
REQ-009 mcu_ack  out  1  one-cycle pulse per accepted strobe.
REQ-010 mcu_busy  out  1  high in LOAD_END, SETTLE and READ.
REQ-011 mcu_err  out  1  sticky error flag.
REQ-012 mul_bus  out  8  byte to the multiplier data input.
REQ-013 mul_in_sel  out  2  operand byte index.
REQ-014 mul_in_en  out  1  multiplier load enable.
REQ-015 mul_out_sel  out  2  result byte index.
REQ-016 mul_out_en  out  1  multiplier readout enable.
REQ-017 mul_bus_rd  in  8  result byte from the multiplier.

Function
REQ-018 Each of mcu_wr and mcu_rd SHALL pass through a 2-flop synchronizer and rising-edge detector, giving a one-cycle event 3 clocks after the strobe edge.
REQ-019 FSM states SHALL be IDLE, LOAD, LOAD_END, SETTLE, READ and DONE.
REQ-020 Operand bytes SHALL be taken MSB first: index 0=A[15:8], 1=A[7:0], 2=B[15:8], 3=B[7:0].
REQ-021 A write event in IDLE or LOAD SHALL do all of the following in the same cycle: set mul_bus=mcu_data_in, set mul_in_sel to the byte index, set mul_in_en=1, pulse mcu_ack, and increment the index.
REQ-022 The write that loads index 3 SHALL move the FSM to LOAD_END.
REQ-023 LOAD_END SHALL hold mul_in_en for 2 cycles, then drive mul_in_en=0 and enter SETTLE.
REQ-024 SETTLE SHALL count exactly SETTLE_CYCLES clocks, then enter READ.
REQ-025 READ SHALL drive mul_out_en=1. For k=0..3 it SHALL set mul_out_sel=k, wait 2 cycles, then capture mul_bus_rd into result byte k (k=0 is the MSB).
REQ-026 After the capture of k=3, the FSM SHALL drive mul_out_en=0 and enter DONE.
REQ-027 In DONE, each read event SHALL drive the next result byte on mcu_data_out (MSB first) and pulse mcu_ack; after the 4th read the FSM SHALL enter IDLE.
REQ-028 A write event in DONE SHALL discard the unread result and start a new LOAD with that byte as index 0.
REQ-029 A write event and a read event in the same cycle in DONE: the write SHALL win and the read SHALL be ignored with no ack.
REQ-030 Write events in LOAD_END, SETTLE or READ SHALL be ignored with no ack and SHALL set mcu_err.
REQ-031 Read events outside DONE SHALL produce no ack, leave mcu_data_out unchanged, and set mcu_err.
REQ-032 mcu_err SHALL clear only on reset or on a write event accepted in IDLE.

Reset
REQ-033 Asserting rst_n low SHALL immediately force state IDLE, byte index 0 and all counters 0.
REQ-034 Asserting rst_n low SHALL immediately force every output to 0, including mcu_data_out, mul_bus and both select outputs.
REQ-035 On reset, synchronizer flops SHALL clear to 0, so a strobe held high across reset release produces no event.
REQ-036 A reset asserted mid-operation in any state SHALL discard all captured operand and result bytes.

Configuration
REQ-037 With MCU_SEQ_TIMEOUT_EN defined, LOAD SHALL count cycles since the last accepted write. On reaching TIMEOUT_CYCLES it SHALL drop mul_in_en, set mcu_err, reset the index to 0 and enter IDLE.
REQ-038 Without MCU_SEQ_TIMEOUT_EN, LOAD SHALL wait indefinitely and no timeout counter SHALL be built.

Structure
REQ-039 Package mcu_seq_pkg SHALL hold the FSM state type, byte-index constants BYTE_MSB=0 and BYTE_LSB=3, and the synchronizer depth constant 2.
REQ-040 The sub-module sync_edge (synchronizer plus rising-edge detect) SHALL be instantiated once for mcu_wr and once for mcu_rd.

Verification
REQ-041 Write 00,0C,00,18; wait for busy=0; issue 4 reads -> mcu_data_out = 00,00,01,20 and 8 ack pulses total.
REQ-042 Write FF,FF,FF,FF; issue 4 reads -> mcu_data_out = FF,FE,00,01; busy high for exactly 2+SETTLE_CYCLES+8 cycles.
REQ-043 Write during SETTLE -> no ack, mcu_err=1, result unaffected; next accepted IDLE write -> mcu_err=0.
REQ-044 Assert rst_n during SETTLE -> all outputs 0 immediately; a following full sequence 00,03,00,05 reads back 00,00,00,0F.
REQ-045 After 2 reads in DONE, write 00 -> LOAD index 1 next; mcu_wr and mcu_rd edges in the same cycle -> only the write is acked.
REQ-046 With MCU_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, write 2 bytes then idle 16 cycles -> IDLE, mcu_err=1, mul_in_en=0.
